// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi -- multi-player reaction timer.
//
// Purpose: after start, waits a pseudo-random delay, then lights go_led
// and times in milliseconds how long until the first react press. A
// press before go ends the round as a false start. No press by
// TIMEOUT_MS ends the round as a timeout.
//
// Optional feature: define REACTION_BEST_TIME_EN to keep the best
// valid time since reset. Without it best_ms is all-ones and new_best
// is 0.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   start_btn         round start (rising edge, IDLE/RESULT only)
//   react_btn[NP]     per-player react buttons
//   go_led, busy      go lamp (TIMING); busy in DELAY or TIMING
//   result_valid      one-cycle pulse on RESULT entry
//   result_ms, winner result of the last round, held until next start
//   false_start       held flag: press before go
//   timeout           held flag: no press by TIMEOUT_MS
//   best_ms, new_best best valid time; pulse when it improves
module reaction_timer_multi #(
  parameter int NUM_PLAYERS     = 2,
  parameter int CLK_PER_MS      = 10000,
  parameter int TIME_W          = 14,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11,
  parameter int TIMEOUT_MS      = 9999,
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] react_btn,
  output logic                   go_led,
  output logic                   busy,
  output logic                   result_valid,
  output logic [TIME_W-1:0]      result_ms,
  output logic [WIN_W-1:0]       winner,
  output logic                   false_start,
  output logic                   timeout,
  output logic [TIME_W-1:0]      best_ms,
  output logic                   new_best
);

  typedef enum logic [1:0] {IDLE, DELAY, TIMING, RESULT} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   start_prev_q;
  logic [NUM_PLAYERS-1:0] react_prev_q;
  logic [PRE_W-1:0]       presc_q, presc_d;
  // One counter serves both phases: remaining delay ms in DELAY,
  // elapsed ms in TIMING.
  logic [TIME_W-1:0]      cnt_q, cnt_d;
  logic [TIME_W-1:0]      result_ms_q, result_ms_d;
  logic [WIN_W-1:0]       winner_q, winner_d;
  logic                   fs_q, fs_d, to_q, to_d, rv_q, rv_d;

  logic                   start_rise, tick;
  logic [NUM_PLAYERS-1:0] react_rise;
  logic [WIN_W-1:0]       press_idx, rise_idx;

  assign start_rise = start_btn & ~start_prev_q;
  assign react_rise = react_btn & ~react_prev_q;
  assign tick       = (presc_q == PRE_W'(CLK_PER_MS - 1));
  // Fibonacci taps 16,14,13,11; a non-zero seed keeps it out of zero.
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    press_idx = '0;
    rise_idx  = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (react_btn[i])  press_idx = WIN_W'(i);
      if (react_rise[i]) rise_idx  = WIN_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= 16'hACE1;
      start_prev_q <= 1'b0;
      react_prev_q <= '0;
      presc_q      <= '0;
      cnt_q        <= '0;
      result_ms_q  <= '0;
      winner_q     <= '0;
      fs_q         <= 1'b0;
      to_q         <= 1'b0;
      rv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= start_btn;
      react_prev_q <= react_btn;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      result_ms_q  <= result_ms_d;
      winner_q     <= winner_d;
      fs_q         <= fs_d;
      to_q         <= to_d;
      rv_q         <= rv_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + PRE_W'(1);
    cnt_d       = cnt_q;
    result_ms_d = result_ms_q;
    winner_d    = winner_q;
    fs_d        = fs_q;
    to_d        = to_q;
    rv_d        = 1'b0;
    case (state_q)
      IDLE, RESULT: begin
        if (start_rise) begin
          state_d     = DELAY;
          presc_d     = '0;
          cnt_d       = TIME_W'(DELAY_MIN_MS) + TIME_W'(lfsr_q[DELAY_RAND_BITS-1:0]);
          result_ms_d = '0;
          winner_d    = '0;
          fs_d        = 1'b0;
          to_d        = 1'b0;
        end
      end
      DELAY: begin
        // Level, not edge: a button held from before start is a false start.
        if (|react_btn) begin
          state_d     = RESULT;
          rv_d        = 1'b1;
          fs_d        = 1'b1;
          result_ms_d = '0;
          winner_d    = press_idx;
        end else if (tick) begin
          if (cnt_q <= TIME_W'(1)) begin
            state_d = TIMING;
            presc_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - TIME_W'(1);
          end
        end
      end
      TIMING: begin
        // Press checked first so a press on the timeout cycle still counts.
        if (|react_rise) begin
          state_d     = RESULT;
          rv_d        = 1'b1;
          result_ms_d = cnt_q;
          winner_d    = rise_idx;
        end else if (cnt_q == TIME_W'(TIMEOUT_MS)) begin
          state_d     = RESULT;
          rv_d        = 1'b1;
          to_d        = 1'b1;
          result_ms_d = TIME_W'(TIMEOUT_MS);
          winner_d    = '0;
        end else if (tick) begin
          cnt_d = cnt_q + TIME_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    go_led = (state_q == TIMING);
    busy   = (state_q == DELAY) || (state_q == TIMING);
  end

  assign result_valid = rv_q;
  assign result_ms    = result_ms_q;
  assign winner       = winner_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] best_q, best_d;
  logic              nb_q, nb_d;
  logic              valid_done;

  // Only a real press during TIMING can set a best time.
  always_comb begin
    valid_done = (state_q == TIMING) && (|react_rise);
    best_d     = best_q;
    nb_d       = 1'b0;
    if (valid_done && (cnt_q < best_q)) begin
      best_d = cnt_q;
      nb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '1;
      nb_q   <= 1'b0;
    end else begin
      best_q <= best_d;
      nb_q   <= nb_d;
    end
  end

  assign best_ms  = best_q;
  assign new_best = nb_q;
`else
  assign best_ms  = '1;
  assign new_best = 1'b0;
`endif

endmodule

// File: doc/reaction_timer_multi.md
REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of react buttons; legal range 1..8.
REQ-002 SHALL have parameter CLK_PER_MS, default 10000, clk cycles per millisecond tick.
REQ-003 SHALL have parameter TIME_W, default 14, width of all millisecond values.
REQ-004 SHALL have parameter DELAY_MIN_MS, default 1000, fixed part of the random pre-go delay.
REQ-005 SHALL have parameter DELAY_RAND_BITS, default 11, width of the random delay addend.
REQ-006 SHALL have parameter TIMEOUT_MS, default 9999, maximum measurable reaction time.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start_btn  in  1  round start; synchronous, debounced.
REQ-010 react_btn  in  NUM_PLAYERS  per-player react buttons; synchronous, debounced.
REQ-011 go_led  out  1  high while reactions are being timed.
REQ-012 busy  out  1  high in DELAY or TIMING.
REQ-013 result_valid  out  1  one-cycle pulse when a round ends.
REQ-014 result_ms  out  TIME_W  measured time of the ended round, held until next round starts.
REQ-015 winner  out  max(1,clog2(NUM_PLAYERS))  index of deciding player, held like result_ms.
REQ-016 false_start  out  1  held flag: round ended by press before go.
REQ-017 timeout  out  1  held flag: nobody pressed before TIMEOUT_MS.
REQ-018 best_ms  out  TIME_W  best valid time since reset.
REQ-019 new_best  out  1  one-cycle pulse, coincident with result_valid, when best_ms improves.

Function
REQ-020 FSM SHALL have states IDLE, DELAY, TIMING, RESULT; IDLE after reset.
REQ-021 start_btn rising edge in IDLE or RESULT SHALL enter DELAY next cycle, clearing result_ms, winner, false_start, timeout; ignored in DELAY/TIMING.
REQ-022 On DELAY entry the delay counter SHALL load DELAY_MIN_MS + LFSR[DELAY_RAND_BITS-1:0].
REQ-023 LFSR SHALL be 16-bit maximal-length Fibonacci (taps 16,14,13,11), seed 16'hACE1, advancing every cycle, never zero.
REQ-024 Prescaler SHALL count 0..CLK_PER_MS-1, emit tick on terminal count, restart at 0 on every DELAY and TIMING entry.
REQ-025 DELAY: each tick decrements delay counter; at zero, enter TIMING with go_led=1 and ms counter=0.
REQ-026 DELAY: any react_btn bit high (level) SHALL end the round: false_start=1, result_ms=0, winner=lowest pressed index, state RESULT.
REQ-027 TIMING: each tick increments ms counter; first cycle with any react_btn rising edge SHALL latch result_ms=ms counter, winner=lowest index among simultaneous edges, state RESULT.
REQ-028 TIMING: ms counter reaching TIMEOUT_MS SHALL set timeout=1, result_ms=TIMEOUT_MS, winner=0, state RESULT; press and timeout in same cycle: press wins.
REQ-029 result_valid SHALL pulse exactly once, in the cycle RESULT is entered; go_led and busy low in IDLE and RESULT.
REQ-030 False-start timing from react press to RESULT entry SHALL be 1 cycle; react-edge to result_valid 1 cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, all counters 0, LFSR seed, all outputs 0 except best_ms = all-ones.
REQ-032 Reset mid-round SHALL discard the round without result_valid.
REQ-033 Button edge detectors SHALL reset to 0, so buttons held across reset release produce an edge.

Configuration
REQ-034 Macro REACTION_BEST_TIME_EN defined: best_ms updates to result_ms on a valid round (no false_start, no timeout) when strictly smaller, with new_best pulse.
REQ-035 Macro undefined: best-time register omitted, best_ms tied all-ones, new_best tied 0.

Verification (NUM_PLAYERS=3, CLK_PER_MS=4, DELAY_MIN_MS=2, DELAY_RAND_BITS=2, TIMEOUT_MS=20)
REQ-036 Start, press react_btn[1] edge 7 ticks after go -> result_ms=7, winner=1, result_valid one pulse, go_led low.
REQ-037 Hold react_btn[2] during DELAY -> false_start=1, result_ms=0, winner=2, best_ms unchanged.
REQ-038 No press after go -> timeout=1, result_ms=20 after 20 ticks; press on that same cycle -> timeout=0, result_ms=20.
REQ-039 react_btn[0] and [2] edges same cycle at tick 5 -> winner=0; then round with 3 -> best_ms=3, new_best pulse (with REACTION_BEST_TIME_EN).
REQ-040 rst_n low during TIMING -> go_led=0 same cycle, no result_valid, best_ms all-ones; start_btn pressed during DELAY ignored.
